// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Consumer end of the load-to-use hazard check. It turns the raw stall request
// from the hazard detector into the pipeline register actions:
//   - PC hold and IF/ID hold
//   - a single NOP bubble injected into ID/EX
//   - arbitration of that bubble against data-memory freezes and branch flushes
//
// Outputs are combinational from the state, the pending-flush flag and the
// inputs. All enables are forced low while rst_n is asserted.
//
// Optional feature: define STALL_CTRL_PERF_CNT_EN to add saturating
// performance counters (lu_bubble_cnt, mem_stall_cnt, flush_cnt) and a
// synchronous clear input cnt_clr.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   load_use_stall in   raw stall request from the load-to-use detector
//   mem_busy       in   data memory not ready, freeze the whole pipeline
//   branch_flush   in   taken branch/jump resolved in EX (redirect pulse)
//   cnt_clr        in   synchronous counter clear (perf feature only)
//   lu_bubble_cnt  out  load-use bubble cycles (perf feature only)
//   mem_stall_cnt  out  memory freeze cycles (perf feature only)
//   flush_cnt      out  flush cycles (perf feature only)
//   pc_en          out  PC register load enable
//   if_id_en       out  IF/ID register enable
//   if_id_flush    out  load NOP into IF/ID
//   id_ex_en       out  ID/EX register enable
//   id_ex_bubble   out  ID/EX loads bubble_instr and zeroed control
//   bubble_instr   out  constant NOP_INSTR
//   back_en        out  EX/MEM and MEM/WB enable
//   state_o        out  current state, for debug
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             mem_busy,
    input  logic             branch_flush,
`ifdef STALL_CTRL_PERF_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] lu_bubble_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic [31:0]      bubble_instr,
    output logic             back_en,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLuBubble = 2'd1,
        StMemWait  = 2'd2,
        StFlush    = 2'd3
    } state_e;

    // Action selected this cycle, in decreasing priority.
    typedef enum logic [1:0] {
        ActFreeze = 2'd0,
        ActSquash = 2'd1,
        ActBubble = 2'd2,
        ActRun    = 2'd3
    } act_e;

    state_e r_state;
    state_e w_state_d;
    logic   r_flush_pend;
    logic   w_flush_pend_d;
    act_e   w_act;

    always_comb begin
        w_act = ActRun;
        if (mem_busy) begin
            w_act = ActFreeze;
        end else if (branch_flush || r_flush_pend) begin
            w_act = ActSquash;
        end else if (load_use_stall && (r_state != StLuBubble)) begin
            // The bubble state masks the detector so one load yields one bubble.
            w_act = ActBubble;
        end
    end

    always_comb begin
        w_state_d      = StRun;
        w_flush_pend_d = r_flush_pend;
        unique case (w_act)
            ActFreeze: begin
                w_state_d = StMemWait;
                // Remember a redirect arriving during the freeze.
                w_flush_pend_d = r_flush_pend | branch_flush;
            end
            ActSquash: begin
                w_state_d      = StFlush;
                w_flush_pend_d = 1'b0;
            end
            ActBubble: w_state_d = StLuBubble;
            ActRun:    w_state_d = StRun;
            default:   w_state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StRun;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_flush_pend <= w_flush_pend_d;
        end
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_bubble = 1'b0;
        back_en      = 1'b0;
        if (rst_n) begin
            unique case (w_act)
                ActFreeze: begin
                    pc_en = 1'b0;
                end
                ActSquash: begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_en     = 1'b1;
                    id_ex_bubble = 1'b1;
                    back_en      = 1'b1;
                end
                ActBubble: begin
                    id_ex_en     = 1'b1;
                    id_ex_bubble = 1'b1;
                    back_en      = 1'b1;
                end
                ActRun: begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    id_ex_en = 1'b1;
                    back_en  = 1'b1;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    assign bubble_instr = NOP_INSTR;
    assign state_o      = rst_n ? r_state : StRun;

`ifdef STALL_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mem_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_cnt    <= '0;
            r_mem_cnt   <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_lu_cnt    <= '0;
            r_mem_cnt   <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_act == ActBubble) && (r_lu_cnt != '1)) begin
                r_lu_cnt <= r_lu_cnt + 1'b1;
            end
            if ((w_act == ActFreeze) && (r_mem_cnt != '1)) begin
                r_mem_cnt <= r_mem_cnt + 1'b1;
            end
            if ((w_act == ActSquash) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign lu_bubble_cnt = r_lu_cnt;
    assign mem_stall_cnt = r_mem_cnt;
    assign flush_cnt     = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    localparam int unsigned CntW = 4;

    logic        clk;
    logic        rst_n;
    logic        load_use_stall;
    logic        mem_busy;
    logic        branch_flush;
    logic        cnt_clr;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_bubble;
    logic [31:0] bubble_instr;
    logic        back_en;
    logic [1:0]  state_o;
`ifdef STALL_CTRL_PERF_CNT_EN
    logic [CntW-1:0] lu_bubble_cnt;
    logic [CntW-1:0] mem_stall_cnt;
    logic [CntW-1:0] flush_cnt;
`endif

    int n_vec;
    int n_err;

    // Reference model: pipeline-level bookkeeping
    int m_state;   // 0 run, 1 bubble just inserted, 2 frozen, 3 flushed
    bit m_pend;    // redirect owed after a freeze
    int m_lu;
    int m_mem;
    int m_fl;

    pipeline_stall_ctrl #(
        .NOP_INSTR(32'h0000_0013),
        .CNT_W    (CntW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_use_stall(load_use_stall),
        .mem_busy      (mem_busy),
        .branch_flush  (branch_flush),
`ifdef STALL_CTRL_PERF_CNT_EN
        .cnt_clr       (cnt_clr),
        .lu_bubble_cnt (lu_bubble_cnt),
        .mem_stall_cnt (mem_stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_en      (id_ex_en),
        .id_ex_bubble  (id_ex_bubble),
        .bubble_instr  (bubble_instr),
        .back_en       (back_en),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // 0 freeze, 1 squash (flush), 2 load-use bubble, 3 normal advance
    function automatic int pick_action(bit lus, bit mb, bit bf);
        if (mb) return 0;
        if (bf || m_pend) return 1;
        if (lus && (m_state != 1)) return 2;
        return 3;
    endfunction

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, back_en}
    function automatic logic [5:0] action_outputs(int act);
        case (act)
            0:       return 6'b000000;
            1:       return 6'b111111;
            2:       return 6'b000111;
            default: return 6'b110101;
        endcase
    endfunction

    function automatic int sat_inc(int v);
        return (v >= (1 << CntW) - 1) ? v : v + 1;
    endfunction

    logic [5:0] obs_outs;

    task automatic step(input bit lus, input bit mb, input bit bf);
        int act;
        load_use_stall = lus;
        mem_busy       = mb;
        branch_flush   = bf;
        #1;
        act      = pick_action(lus, mb, bf);
        obs_outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, back_en};
        check("outs", {26'd0, obs_outs}, {26'd0, action_outputs(act)});
        check("state", {30'd0, state_o}, m_state);
        check("nop", bubble_instr, 32'h0000_0013);
`ifdef STALL_CTRL_PERF_CNT_EN
        check("lu_cnt", {28'd0, lu_bubble_cnt}, m_lu);
        check("mem_cnt", {28'd0, mem_stall_cnt}, m_mem);
        check("fl_cnt", {28'd0, flush_cnt}, m_fl);
`endif
        @(posedge clk);
        if (mb) m_pend = m_pend | bf;
        else if (act == 1) m_pend = 1'b0;
        case (act)
            0:       m_state = 2;
            1:       m_state = 3;
            2:       m_state = 1;
            default: m_state = 0;
        endcase
        if (cnt_clr) begin
            m_lu = 0; m_mem = 0; m_fl = 0;
        end else begin
            if (act == 0) m_mem = sat_inc(m_mem);
            if (act == 1) m_fl  = sat_inc(m_fl);
            if (act == 2) m_lu  = sat_inc(m_lu);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        load_use_stall = 1'($urandom);
        mem_busy       = 1'($urandom);
        branch_flush   = 1'($urandom);
        #1;
        check("rst_outs", {26'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, back_en},
              32'd0);
        check("rst_state", {30'd0, state_o}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold", {26'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, back_en},
              32'd0);
`ifdef STALL_CTRL_PERF_CNT_EN
        check("rst_cnt", {20'd0, lu_bubble_cnt, mem_stall_cnt, flush_cnt}, 32'd0);
`endif
        load_use_stall = 1'b0;
        mem_busy       = 1'b0;
        branch_flush   = 1'b0;
        rst_n          = 1'b1;
        m_state = 0; m_pend = 1'b0;
        m_lu = 0; m_mem = 0; m_fl = 0;
    endtask

    initial begin
        int nbub;
        n_vec = 0;
        n_err = 0;
        cnt_clr = 1'b0;
        rst_n = 1'b0;
        load_use_stall = 1'b0;
        mem_busy = 1'b0;
        branch_flush = 1'b0;
        #2;
        do_reset();
        step(0, 0, 0);

        // Single bubble with a two-cycle stall request
        nbub = 0;
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0);
            if (obs_outs[1] && !obs_outs[3]) nbub++;
        end
        check("one_bubble", nbub, 1);
        step(0, 0, 0);

        // Memory freeze with load-use pending, then one bubble
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        // Branch during freeze, redirect on first free cycle
        step(0, 1, 1);
        step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        // Flush beats load-use
        step(1, 0, 1);
        check("flush_state", {30'd0, state_o}, 32'd3);
        step(0, 0, 0);

        // Reset mid-operation with a pending flush
        step(0, 1, 1);
        do_reset();
        step(0, 0, 0);

`ifdef STALL_CTRL_PERF_CNT_EN
        cnt_clr = 1'b1;
        step(0, 0, 0);
        cnt_clr = 1'b0;
        for (int i = 0; i < 40; i++) step(1, 0, 0);
        check("lu_sat", {28'd0, lu_bubble_cnt}, 32'hF);
        cnt_clr = 1'b1;
        step(1, 0, 0);
        cnt_clr = 1'b0;
        check("lu_clr", {28'd0, lu_bubble_cnt}, 32'd0);
        step(0, 0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99, 0) < 2) begin
                do_reset();
            end else begin
`ifdef STALL_CTRL_PERF_CNT_EN
                cnt_clr = ($urandom_range(99, 0) < 3);
`endif
                step(($urandom_range(99, 0) < 50), ($urandom_range(99, 0) < 25),
                     ($urandom_range(99, 0) < 15));
            end
        end
        cnt_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Consumer end of the load-to-use hazard check. It takes the combinational stall request from the hazard detector and turns it into the actual pipeline actions:
- PC hold and IF/ID hold.
- A single NOP bubble injected into ID/EX.
- Arbitration of that bubble against data-memory wait freezes and taken-branch flushes.

It sits between the hazard/branch logic and the pipeline register enables in the 5-stage CPU.

Parameters:
- NOP_INSTR, 32'h0000_0013, instruction word placed on bubble_instr (addi x0,x0,0).
- CNT_W, 32, width of the performance counters (only used with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_use_stall  in  1  raw stall request from the load-to-use hazard detector.
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- branch_flush  in  1  taken branch/jump resolved in EX; redirect pulse.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_bubble  out  1  ID/EX loads bubble_instr and zeroed control instead of the decode outputs.
- bubble_instr  out  32  constant NOP_INSTR.
- back_en  out  1  EX/MEM and MEM/WB enable.
- state_o  out  2  current state, for debug.

Behaviour:
- State register, 2 bits: RUN=0, LU_BUBBLE=1, MEM_WAIT=2, FLUSH=3. Reset state is RUN.
- flush_pend: 1-bit register, reset 0.
- Outputs are combinational from state, flush_pend and inputs, evaluated in the priority order below.
- While rst_n=0, all outputs are forced to:
  - pc_en=0, if_id_en=0, id_ex_en=0, back_en=0
  - if_id_flush=0, id_ex_bubble=0
  - state_o=0
- Priority 1, mem_busy=1:
  - Outputs: pc_en=if_id_en=id_ex_en=back_en=0; flush=bubble=0.
  - Next state: MEM_WAIT.
  - If branch_flush=1 in this cycle, set flush_pend=1 so the redirect is not lost.
  - load_use_stall is ignored; it is re-evaluated after the freeze.
- Priority 2, branch_flush=1 or flush_pend=1:
  - Outputs: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_bubble=1, back_en=1.
  - Clear flush_pend. Next state: FLUSH.
  - load_use_stall is ignored because the dependent instruction is being squashed.
- Priority 3, load_use_stall=1 and state!=LU_BUBBLE:
  - Outputs: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, back_en=1.
  - Next state: LU_BUBBLE.
  - Exactly one bubble is inserted; the load result is then forwarded from MEM/WB.
- Priority 4, default:
  - Outputs: all enables 1, flush=bubble=0.
  - Next state: RUN.
- Mask rule: in LU_BUBBLE, load_use_stall is masked for that one cycle, even if the detector glitches high. A single load never causes two bubbles.
- FLUSH and MEM_WAIT are single-transit states. Their only effect on the next cycle is through the priority rules above.
- A load-use request seen in MEM_WAIT is honoured on the first cycle after mem_busy falls, as a normal priority-3 bubble.
- Reset mid-operation (any state, flush_pend set): returns to RUN with flush_pend=0 immediately; no pending bubble survives.
- bubble_instr always equals NOP_INSTR, independent of state.

Optional Feature:
Macro STALL_CTRL_PERF_CNT_EN.
- Defined: adds outputs lu_bubble_cnt, mem_stall_cnt and flush_cnt, each CNT_W wide.
  - They increment, respectively, on each priority-3 cycle, each priority-1 cycle, and each priority-2 cycle.
  - They saturate at all-ones.
  - They reset asynchronously to 0.
  - They clear synchronously when input cnt_clr=1; clear wins over increment.
- Undefined: the counter ports and cnt_clr do not exist; no extra flops.

Test Plan:
- Reset check: rst_n=0 with random inputs -> all enables 0, state_o=0. Release rst_n with idle inputs -> all enables 1 on the next cycle.
- Single bubble: load_use_stall high for 2 consecutive cycles.
  - Cycle 1: pc_en=0, if_id_en=0, id_ex_bubble=1, state_o=1.
  - Cycle 2: masked, so pc_en=1 and bubble=0.
  - Exactly 1 bubble in total.
- Memory freeze: mem_busy high for 3 cycles with load_use_stall=1 throughout.
  - During the freeze: all enables 0 for 3 cycles.
  - Then 1 bubble cycle, then RUN.
- Branch during freeze: branch_flush pulse while mem_busy=1, then mem_busy falls.
  - On the first free cycle: if_id_flush=1, id_ex_bubble=1, pc_en=1, flush_pend cleared.
- Flush beats load-use: branch_flush=1 and load_use_stall=1 in the same cycle -> if_id_flush=1, pc_en=1, state_o=3, no hold.
- With STALL_CTRL_PERF_CNT_EN, CNT_W=4:
  - 20 bubble events -> lu_bubble_cnt=4'hF.
  - cnt_clr pulsed in the same cycle as a bubble -> lu_bubble_cnt=0.
